// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: ID instruction fields and flush in, stall/forwarding hints and pending mask out.
// master = decode/datapath side, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic            id_wr_en;
  logic [AW-1:0]   id_wrreg;
  logic [CW-1:0]   id_lat;
  logic            flush;
  logic            stall;
  logic            rs_fwd;
  logic [CW-1:0]   rs_age;
  logic            rt_fwd;
  logic [CW-1:0]   rt_age;
  logic [NREG-1:0] pend_mask;
  logic [31:0]     stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wrreg, id_lat, flush,
    input  stall, rs_fwd, rs_age, rt_fwd, rt_age, pend_mask, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wrreg, id_lat, flush,
    output stall, rs_fwd, rs_age, rt_fwd, rt_age, pend_mask, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for ID: stall/forward hints are combinational from registered state; stall is the only backpressure.
// Optional stall-cycle statistics counter enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int MAXLAT    = 4,
  parameter int CW        = 3,
  parameter int WB_DIST   = 3,
  parameter int FLUSH_WIN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave hz
);
  localparam logic [CW-1:0] LAT_MAX  = CW'(MAXLAT);
  localparam logic [CW-1:0] AGE_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] WB_AGE   = CW'(WB_DIST);
  localparam logic [CW-1:0] KILL_AGE = CW'(FLUSH_WIN);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [NREG-1:0] busy_q;
  logic [CW-1:0]   cnt_q   [NREG];
  logic [CW-1:0]   age_q   [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [CW-1:0]   age_nxt [NREG];

  logic          rs_src, rt_src;
  logic          rs_haz, rt_haz;
  logic          stall, fire;
  logic          rs_fwd, rt_fwd;
  logic [CW-1:0] rs_age, rt_age;
  logic [CW-1:0] lat_clamp;

  // A source is in flight when it names a busy non-zero register; it is a hazard
  // only while more than one cycle remains before its result can be forwarded.
  always_comb begin
    rs_src    = hz.id_rs_used && (hz.id_rs != '0) && busy_q[hz.id_rs];
    rt_src    = hz.id_rt_used && (hz.id_rt != '0) && busy_q[hz.id_rt];
    rs_haz    = rs_src && (cnt_q[hz.id_rs] > ONE);
    rt_haz    = rt_src && (cnt_q[hz.id_rt] > ONE);
    stall     = hz.id_valid && !hz.flush && (rs_haz || rt_haz);
    rs_fwd    = rs_src && (cnt_q[hz.id_rs] <= ONE) && !stall;
    rt_fwd    = rt_src && (cnt_q[hz.id_rt] <= ONE) && !stall;
    rs_age    = rs_fwd ? (age_q[hz.id_rs] + ONE) : '0;
    rt_age    = rt_fwd ? (age_q[hz.id_rt] + ONE) : '0;
    fire      = hz.id_valid && !stall && !hz.flush && hz.id_wr_en &&
                (hz.id_wrreg != '0) && (hz.id_lat != '0);
    lat_clamp = (hz.id_lat > LAT_MAX) ? LAT_MAX : hz.id_lat;
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = (cnt_q[i] == '0) ? '0 : (cnt_q[i] - ONE);
      age_nxt[i] = (age_q[i] == AGE_SAT) ? AGE_SAT : (age_q[i] + ONE);
    end
  end

  // Register 0 is never written, so its entry stays idle from reset onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (fire && (hz.id_wrreg == AW'(i))) begin
          busy_q[i] <= 1'b1;
          cnt_q[i]  <= lat_clamp;
          age_q[i]  <= '0;
        end else if (busy_q[i]) begin
          // Young entries die on flush; a slow producer outlives WB_DIST until its count drains.
          if ((hz.flush && (age_q[i] < KILL_AGE)) ||
              ((age_nxt[i] >= WB_AGE) && (cnt_nxt[i] == '0))) begin
            busy_q[i] <= 1'b0;
            cnt_q[i]  <= '0;
            age_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_nxt[i];
            age_q[i] <= age_nxt[i];
          end
        end
      end
    end
  end

  assign hz.stall     = stall;
  assign hz.rs_fwd    = rs_fwd;
  assign hz.rs_age    = rs_age;
  assign hz.rt_fwd    = rt_fwd;
  assign hz.rt_age    = rt_age;
  assign hz.pend_mask = busy_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs from a timeline model of issue/ready/retire times; monitor compares at negedge.
module tb_hazard_scoreboard;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int CW     = 3;
  localparam int MAXLAT = 4;
  localparam int WB     = 3;
  localparam int FW     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .CW(CW)) hz();

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .CW(CW), .WB_DIST(WB), .FLUSH_WIN(FW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    int            cyc;
    bit            stall;
    bit            rs_fwd;
    bit [CW-1:0]   rs_age;
    bit            rt_fwd;
    bit [CW-1:0]   rt_age;
    bit [NREG-1:0] pend;
    bit [31:0]     scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model: each register remembers the cycle its producer issued and its clamped latency.
  bit m_valid [NREG];
  int m_c     [NREG];
  int m_l     [NREG];
  int cyc     = 0;
  int m_scnt  = 0;

  function automatic bit alive(int r);
    int span;
    span = (m_l[r] > WB) ? m_l[r] : WB;
    return m_valid[r] && (cyc <= m_c[r] + span);
  endfunction

  function automatic bit not_ready(int r);
    return cyc < m_c[r] + m_l[r];
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
  endtask

  task automatic step(input bit rst, input bit v, input int rs, input int rt,
                      input bit rsu, input bit rtu, input bit we, input int wr,
                      input int lat, input bit fl);
    exp_t e;
    bit   rs_src, rt_src, rs_h, rt_h, fire;
    @(posedge clk);
    #1;
    rst_n         = !rst;
    hz.id_valid   = v;
    hz.id_rs      = AW'(rs);
    hz.id_rt      = AW'(rt);
    hz.id_rs_used = rsu;
    hz.id_rt_used = rtu;
    hz.id_wr_en   = we;
    hz.id_wrreg   = AW'(wr);
    hz.id_lat     = CW'(lat);
    hz.flush      = fl;
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_valid[r] = 1'b0;
      m_scnt = 0;
    end
    rs_src   = rsu && (rs != 0) && alive(rs);
    rt_src   = rtu && (rt != 0) && alive(rt);
    rs_h     = rs_src && not_ready(rs);
    rt_h     = rt_src && not_ready(rt);
    e.cyc    = cyc;
    e.stall  = v && !fl && (rs_h || rt_h);
    e.rs_fwd = rs_src && !not_ready(rs) && !e.stall;
    e.rt_fwd = rt_src && !not_ready(rt) && !e.stall;
    e.rs_age = e.rs_fwd ? CW'(cyc - m_c[rs]) : '0;
    e.rt_age = e.rt_fwd ? CW'(cyc - m_c[rt]) : '0;
    for (int r = 0; r < NREG; r++) e.pend[r] = (r != 0) && alive(r);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    e.scnt = 32'(m_scnt);
`else
    e.scnt = 32'd0;
`endif
    exp_q.push_back(e);
    if (!rst) begin
      if (e.stall) m_scnt++;
      if (fl) begin
        for (int r = 1; r < NREG; r++)
          if (alive(r) && (cyc - m_c[r] - 1 < FW)) m_valid[r] = 1'b0;
      end
      fire = v && !e.stall && !fl && we && (wr != 0) && (lat != 0);
      if (fire) begin
        m_valid[wr] = 1'b1;
        m_c[wr]     = cyc;
        m_l[wr]     = (lat > MAXLAT) ? MAXLAT : lat;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_op(input int rd, input int lat);
    step(0, 1, 0, 0, 0, 0, 1, rd, lat, 0);
  endtask

  // Monitor: one expected record per cycle, compared away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall",     e.cyc, 32'(hz.stall),  32'(e.stall));
        chk("rs_fwd",    e.cyc, 32'(hz.rs_fwd), 32'(e.rs_fwd));
        chk("rs_age",    e.cyc, 32'(hz.rs_age), 32'(e.rs_age));
        chk("rt_fwd",    e.cyc, 32'(hz.rt_fwd), 32'(e.rt_fwd));
        chk("rt_age",    e.cyc, 32'(hz.rt_age), 32'(e.rt_age));
        chk("pend_mask", e.cyc, hz.pend_mask,   e.pend);
        chk("stall_cnt", e.cyc, hz.stall_cnt,   e.scnt);
      end
    end
  end

  initial begin
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 4, 1, 1, 1, 5, 2, 0);
    idle(1);

    // ALU producer, dependent add next cycle: forward at age 1
    wr_op(3, 1);
    step(0, 1, 3, 0, 1, 0, 1, 4, 1, 0);
    idle(4);

    // load then add $2,$1,$1 held in ID: one stall, then forward age 2 on both sources
    wr_op(1, 2);
    step(0, 1, 1, 1, 1, 1, 1, 2, 1, 0);
    step(0, 1, 1, 1, 1, 1, 1, 2, 1, 0);
    idle(4);

    // latency-4 producer (requested 6, clamped): three stalls, issue on the fourth
    wr_op(5, 6);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 5, 0, 1, 0, 0, 0, 0);
    idle(5);

    // flush kills the young $7 entry and the ID instruction; older $8 survives
    wr_op(8, 1);
    idle(1);
    wr_op(7, 1);
    step(0, 1, 7, 8, 1, 1, 1, 10, 1, 1);
    step(0, 1, 7, 8, 1, 1, 0, 0, 0, 0);
    idle(3);

    // $0 destination, zero latency and $0 sources never create state
    wr_op(0, 2);
    wr_op(6, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0, 3, 0);
    step(0, 1, 6, 0, 1, 1, 0, 0, 0, 0);
    idle(2);

    // reset in the middle of a multi-cycle stall, then the stall case again
    wr_op(5, 4);
    step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    wr_op(5, 4);
    for (int k = 0; k < 4; k++) step(0, 1, 5, 0, 1, 0, 1, 9, 1, 0);
    idle(5);

    // randomized traffic on a small register window to provoke overlaps
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
